// File: rtl/sdm_ni_tx.sv
// Network-interface transmitter: flits are buffered in a small FIFO and sent as 1-of-4
// delay-insensitive codewords using a four-phase return-to-zero handshake on oa.
module sdm_ni_tx #(
  parameter int DW  = 8,
  parameter int SCN = DW / 2,
  parameter int FD  = 4,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic           in_eof,
  output logic [SCN-1:0] o0,
  output logic [SCN-1:0] o1,
  output logic [SCN-1:0] o2,
  output logic [SCN-1:0] o3,
  output logic           o4,
  input  logic           oa,
  output logic           busy,
  output logic [CW-1:0]  tok_cnt
);

  localparam int AW = (FD > 1) ? $clog2(FD) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SET = 2'd1, RTZ = 2'd2} state_t;

  state_t         state_reg, state_next;
  logic [DW:0]    mem [FD];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    count_reg, count_next;
  logic           oa_meta_reg, oa_s_reg;
  logic [SCN-1:0] o0_reg, o1_reg, o2_reg, o3_reg;
  logic           o4_reg;
  logic [CW-1:0]  tok_reg;
  logic           push, pop, rail_clr, full, empty;
  logic [DW:0]    head;
  logic [SCN-1:0] enc0, enc1, enc2, enc3;

  assign full     = (count_reg == (AW+1)'(FD));
  assign empty    = (count_reg == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr_reg];

  // Storage has no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {in_eof, in_data};
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Eof tokens suppress every data rail so only o4 is raised.
  for (genvar gi = 0; gi < SCN; gi++) begin : g_enc
    logic [1:0] sym;
    assign sym      = head[2*gi +: 2];
    assign enc0[gi] = !head[DW] && (sym == 2'd0);
    assign enc1[gi] = !head[DW] && (sym == 2'd1);
    assign enc2[gi] = !head[DW] && (sym == 2'd2);
    assign enc3[gi] = !head[DW] && (sym == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oa_meta_reg <= 1'b0;
      oa_s_reg    <= 1'b0;
    end else begin
      oa_meta_reg <= oa;
      oa_s_reg    <= oa_meta_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    rail_clr   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty && !oa_s_reg) begin
          state_next = SET;
          pop        = 1'b1;
        end
      end
      SET: begin
        if (oa_s_reg) begin
          state_next = RTZ;
          rail_clr   = 1'b1;
        end
      end
      RTZ: begin
        if (!oa_s_reg) begin
          if (!empty) begin
            state_next = SET;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tok_reg   <= '0;
      o0_reg    <= '0;
      o1_reg    <= '0;
      o2_reg    <= '0;
      o3_reg    <= '0;
      o4_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        o0_reg <= enc0;
        o1_reg <= enc1;
        o2_reg <= enc2;
        o3_reg <= enc3;
        o4_reg <= head[DW];
      end else if (rail_clr) begin
        o0_reg <= '0;
        o1_reg <= '0;
        o2_reg <= '0;
        o3_reg <= '0;
        o4_reg <= 1'b0;
      end
      if (rail_clr) tok_reg <= tok_reg + 1'b1;
    end
  end

  assign o0      = o0_reg;
  assign o1      = o1_reg;
  assign o2      = o2_reg;
  assign o3      = o3_reg;
  assign o4      = o4_reg;
  assign tok_cnt = tok_reg;
  assign busy    = !empty || (state_reg != IDLE);

endmodule

// File: tb/tb_sdm_ni_tx.sv
// Bench for sdm_ni_tx: acts as the receiving router, decoding codewords against a queue of
// accepted flits and acknowledging each with a four-phase handshake.
module tb_sdm_ni_tx;
  localparam int DW  = 8;
  localparam int SCN = DW / 2;
  localparam int FD  = 4;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, in_eof, oa, o4, busy;
  logic [DW-1:0]  in_data;
  logic [SCN-1:0] o0, o1, o2, o3;
  logic [CW-1:0]  tok_cnt;

  int          checks   = 0;
  int          failures = 0;
  int          tok_model = 0;
  logic [DW:0] exp_q [$];

  always #5 clk = ~clk;

  sdm_ni_tx #(.DW(DW), .SCN(SCN), .FD(FD), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_eof(in_eof), .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .o4(o4), .oa(oa), .busy(busy), .tok_cnt(tok_cnt)
  );

  // Expected rails {o4,o3,o2,o1,o0}: rail v of sub-channel k lives at bit v*SCN+k.
  function automatic logic [4*SCN:0] enc(input logic [DW:0] f);
    logic [4*SCN:0] r;
    int v;
    r = '0;
    if (f[DW]) r[4*SCN] = 1'b1;
    else begin
      for (int k = 0; k < SCN; k++) begin
        v = (int'(f[DW-1:0]) >> (2 * k)) & 3;
        r[v * SCN + k] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [DW:0] f);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = f[DW-1:0];
    in_eof   = f[DW];
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_eof   = 1'($urandom);
    check("push_accept", 64'(ok), 64'd1);
    if (ok) exp_q.push_back(f);
  endtask

  task automatic wait_rails();
    for (int i = 0; i < 30 && {o4, o3, o2, o1, o0} == '0; i++) step(1);
  endtask

  // One full token: verify codeword, ack with exact two-edge latency, release ack.
  task automatic handshake();
    logic [DW:0] f;
    wait_rails();
    f = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("codeword", 64'({o4, o3, o2, o1, o0}), 64'(enc(f)));
    step($urandom_range(0, 3));
    check("hold", 64'({o4, o3, o2, o1, o0}), 64'(enc(f)));
    oa = 1'b1;
    step(2);
    check("ack_latency", 64'({o4, o3, o2, o1, o0}), 64'(enc(f)));
    step(1);
    check("rtz", 64'({o4, o3, o2, o1, o0}), 64'd0);
    tok_model = (tok_model + 1) % (1 << CW);
    check("tok_cnt", 64'(tok_cnt), 64'(tok_model));
    step($urandom_range(0, 2));
    oa = 1'b0;
  endtask

  initial begin
    logic [DW:0] f;
    rst = 1'b1; oa = 1'b0; in_valid = 1'b0; in_data = '0; in_eof = 1'b0;
    step(2);
    check("rst_rails", 64'({o4, o3, o2, o1, o0}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tok", 64'(tok_cnt), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // Single flit 0xB4: no bypass, then exact codeword.
    in_valid = 1'b1; in_data = 8'hB4; in_eof = 1'b0;
    step(1);
    in_valid = 1'b0;
    exp_q.push_back({1'b0, 8'hB4});
    check("no_bypass", 64'({o4, o3, o2, o1, o0}), 64'd0);
    check("busy_fifo", 64'(busy), 64'd1);
    step(1);
    check("b4_o0", 64'(o0), 64'h1);
    check("b4_o1", 64'(o1), 64'h2);
    check("b4_o2", 64'(o2), 64'h8);
    check("b4_o3", 64'(o3), 64'h4);
    check("b4_o4", 64'(o4), 64'h0);
    handshake();
    step(2);
    check("busy_in_rtz", 64'(busy), 64'd1);
    step(1);
    check("idle_busy", 64'(busy), 64'd0);

    // Five flits back-to-back with no ack: one in flight, four fill the FIFO.
    for (int i = 0; i < 5; i++) begin
      f = {1'b0, 8'($urandom)};
      in_valid = 1'b1; in_data = f[DW-1:0]; in_eof = 1'b0;
      check("b2b_ready", 64'(in_ready), 64'd1);
      exp_q.push_back(f);
      step(1);
    end
    check("full_ready", 64'(in_ready), 64'd0);
    in_data = 8'($urandom);
    step(1);
    in_valid = 1'b0;
    check("full_ready_hold", 64'(in_ready), 64'd0);
    handshake();
    step(3);
    check("slot_freed", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) handshake();
    check("tok_after_burst", 64'(tok_cnt), 64'd6);
    step(4);
    check("burst_idle", 64'(busy), 64'd0);

    // End-of-frame token ignores in_data.
    push({1'b1, 8'hFF});
    wait_rails();
    check("eof_o4", 64'(o4), 64'd1);
    check("eof_data", 64'({o3, o2, o1, o0}), 64'd0);
    handshake();
    step(4);
    check("eof_idle", 64'(busy), 64'd0);

    // Reset mid-handshake with ack high, then a stale ack must block the next token.
    push({1'b0, 8'($urandom)});
    push({1'b0, 8'($urandom)});
    wait_rails();
    oa = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    check("rst_mid_rails", 64'({o4, o3, o2, o1, o0}), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_tok", 64'(tok_cnt), 64'd0);
    exp_q.delete();
    tok_model = 0;
    rst = 1'b0;
    step(2);
    push({1'b0, 8'h00});
    for (int i = 0; i < 4; i++) begin
      check("stale_ack", 64'({o4, o3, o2, o1, o0}), 64'd0);
      step(1);
    end
    check("stale_busy", 64'(busy), 64'd1);
    oa = 1'b0;
    wait_rails();
    check("zero_o0", 64'(o0), 64'hF);
    handshake();

    // Random traffic until the token counter wraps.
    for (int i = 0; i < 300 && tok_model != (1 << CW) - 1; i++) begin
      push({1'($urandom_range(0, 7) == 0), 8'($urandom)});
      handshake();
    end
    check("tok_max", 64'(tok_cnt), 64'((1 << CW) - 1));
    push({1'b0, 8'($urandom)});
    handshake();
    check("tok_wrap", 64'(tok_cnt), 64'd0);
    step(4);
    check("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
